// File: rtl/seq_det_pkg.sv
// Shared defaults and width helpers for the parameterised serial sequence detector.
package seq_det_pkg;

    localparam int DEF_PAT_W = 4;
    localparam int DEF_CNT_W = 8;
    localparam logic [DEF_PAT_W-1:0] DEF_PAT_RST = 4'b1011;

    // Width of the matched-prefix output; kept at least 1 bit for tiny patterns.
    function automatic int state_w(input int pat_w);
        return (pat_w > 2) ? $clog2(pat_w) : 1;
    endfunction

    // Fill count runs 0..pat_w inclusive.
    function automatic int fill_w(input int pat_w);
        return $clog2(pat_w + 1);
    endfunction

endpackage

// File: rtl/seq_det_prefix.sv
// Combinational next-state logic: shifts in one bit, updates the fill count and finds
// the longest pattern prefix that is also a suffix of the accepted bits.
module seq_det_prefix
    import seq_det_pkg::*;
#(
    parameter int PAT_W = DEF_PAT_W
) (
    input  logic [PAT_W-2:0]          hist,
    input  logic [fill_w(PAT_W)-1:0]  fill,
    input  logic [PAT_W-1:0]          pat,
    input  logic                      inp,
    input  logic                      overlap,
    output logic [PAT_W-2:0]          hist_nx,
    output logic [fill_w(PAT_W)-1:0]  fill_nx,
    output logic [state_w(PAT_W)-1:0] state_nx,
    output logic                      match
);

    localparam int STATE_W = state_w(PAT_W);
    localparam int FILL_W  = fill_w(PAT_W);
    localparam logic [FILL_W-1:0] FILL_FULL = FILL_W'(PAT_W);

    logic [PAT_W-1:0]   window;
    logic [PAT_W-1:0]   mask;
    logic [PAT_W-1:0]   pref;
    logic [FILL_W-1:0]  fill_inc;
    logic [STATE_W-1:0] border;
    logic               ok;

    always_comb begin
        // Only PAT_W-1 older bits are stored; the bit arriving now completes the window.
        window   = {hist, inp};
        fill_inc = (fill == FILL_FULL) ? FILL_FULL : fill + 1'b1;
        border   = '0;
        mask     = '0;
        pref     = '0;
        ok       = 1'b0;
        // Ascending scan leaves the longest qualifying prefix length in border.
        for (int k = 1; k < PAT_W; k++) begin
            mask = PAT_W'((1 << k) - 1);
            pref = pat >> (PAT_W - k);
            ok   = (FILL_W'(k) <= fill_inc) && (((window ^ pref) & mask) == '0);
            if (ok) begin
                border = STATE_W'(k);
            end
        end
        match   = (fill_inc == FILL_FULL) && (window == pat);
        hist_nx = window[PAT_W-2:0];
        if (match && !overlap) begin
            fill_nx  = '0;
            state_nx = '0;
        end else begin
            fill_nx  = fill_inc;
            state_nx = border;
        end
    end

endmodule

// File: rtl/seq_detector_param.sv
// Serial pattern detector with loadable pattern, overlap control and a saturating
// match counter; all registers live here, the prefix logic is in seq_det_prefix.
module seq_detector_param
    import seq_det_pkg::*;
#(
    parameter int               PAT_W   = DEF_PAT_W,
    parameter int               CNT_W   = DEF_CNT_W,
    parameter logic [PAT_W-1:0] PAT_RST = PAT_W'(DEF_PAT_RST)
) (
    input  logic                      clk,
    input  logic                      rst,
    input  logic                      en,
    input  logic                      inp,
    input  logic                      load,
    input  logic [PAT_W-1:0]          pattern_in,
    input  logic                      overlap,
    output logic                      outp,
    output logic [state_w(PAT_W)-1:0] state,
    output logic [CNT_W-1:0]          match_cnt
);

    localparam int STATE_W = state_w(PAT_W);
    localparam int FILL_W  = fill_w(PAT_W);

    function automatic logic [CNT_W-1:0] sat_inc(input logic [CNT_W-1:0] v);
        return (&v) ? v : v + 1'b1;
    endfunction

    logic [PAT_W-1:0]   pat_q,   pat_d;
    logic [PAT_W-2:0]   hist_q,  hist_d;
    logic [FILL_W-1:0]  fill_q,  fill_d;
    logic [STATE_W-1:0] state_q, state_d;
    logic [CNT_W-1:0]   cnt_q,   cnt_d;
    logic               outp_q,  outp_d;

    logic [PAT_W-2:0]   hist_nx;
    logic [FILL_W-1:0]  fill_nx;
    logic [STATE_W-1:0] state_nx;
    logic               match;

    seq_det_prefix #(
        .PAT_W (PAT_W)
    ) u_prefix (
        .hist     (hist_q),
        .fill     (fill_q),
        .pat      (pat_q),
        .inp      (inp),
        .overlap  (overlap),
        .hist_nx  (hist_nx),
        .fill_nx  (fill_nx),
        .state_nx (state_nx),
        .match    (match)
    );

    always_comb begin
        pat_d   = pat_q;
        hist_d  = hist_q;
        fill_d  = fill_q;
        state_d = state_q;
        cnt_d   = cnt_q;
        outp_d  = 1'b0;
        // A load wins over en; the bit presented with it is dropped.
        if (load) begin
            pat_d   = pattern_in;
            hist_d  = '0;
            fill_d  = '0;
            state_d = '0;
            cnt_d   = '0;
        end else if (en) begin
            hist_d  = hist_nx;
            fill_d  = fill_nx;
            state_d = state_nx;
            outp_d  = match;
            if (match) begin
                cnt_d = sat_inc(cnt_q);
            end
        end
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            pat_q   <= PAT_RST;
            hist_q  <= '0;
            fill_q  <= '0;
            state_q <= '0;
            cnt_q   <= '0;
            outp_q  <= 1'b0;
        end else begin
            pat_q   <= pat_d;
            hist_q  <= hist_d;
            fill_q  <= fill_d;
            state_q <= state_d;
            cnt_q   <= cnt_d;
            outp_q  <= outp_d;
        end
    end

    assign outp      = outp_q;
    assign state     = state_q;
    assign match_cnt = cnt_q;

endmodule

// File: tb/tb_seq_detector_param.sv
// Bench for seq_detector_param: directed scenarios plus randomized traffic checked
// against a queue-based reference model; a CNT_W=2 instance shares all inputs.
module tb_seq_detector_param;

    localparam int PW = 4;

    localparam int ST_OVL[7] = '{1, 2, 3, 1, 2, 3, 1};
    localparam int ST_NOV[7] = '{1, 2, 3, 0, 0, 1, 1};
    localparam int PU_OVL[7] = '{0, 0, 0, 1, 0, 0, 1};
    localparam int PU_NOV[7] = '{0, 0, 0, 1, 0, 0, 0};
    localparam int STREAM[7] = '{1, 0, 1, 1, 0, 1, 1};

    logic       clk = 1'b0;
    logic       rst = 1'b0;
    logic       en = 1'b0;
    logic       inp = 1'b0;
    logic       load = 1'b0;
    logic       overlap = 1'b0;
    logic [3:0] pattern_in = 4'b0000;

    logic       outp, outp2;
    logic [1:0] state, state2;
    logic [7:0] cnt;
    logic [1:0] cnt2;

    int n_checks = 0;
    int n_fail = 0;

    // Reference model state
    logic [3:0] m_pat;
    bit         m_q[$];
    int         m_cnt;
    int         m_state;
    bit         m_outp;

    always #5 clk = ~clk;

    seq_detector_param #(.PAT_W(4), .CNT_W(8), .PAT_RST(4'b1011)) dut (
        .clk(clk), .rst(rst), .en(en), .inp(inp), .load(load),
        .pattern_in(pattern_in), .overlap(overlap),
        .outp(outp), .state(state), .match_cnt(cnt)
    );

    seq_detector_param #(.PAT_W(4), .CNT_W(2), .PAT_RST(4'b1011)) dut2 (
        .clk(clk), .rst(rst), .en(en), .inp(inp), .load(load),
        .pattern_in(pattern_in), .overlap(overlap),
        .outp(outp2), .state(state2), .match_cnt(cnt2)
    );

    function automatic int m_border();
        for (int k = PW - 1; k >= 1; k--) begin
            if (k <= m_q.size()) begin
                bit ok;
                ok = 1'b1;
                for (int j = 0; j < k; j++)
                    if (m_q[m_q.size() - k + j] != m_pat[PW - 1 - j]) ok = 1'b0;
                if (ok) return k;
            end
        end
        return 0;
    endfunction

    task automatic model_reset();
        m_pat = 4'b1011;
        m_q.delete();
        m_cnt = 0;
        m_state = 0;
        m_outp = 1'b0;
    endtask

    task automatic model_step(input bit e, input bit b, input bit l, input logic [3:0] p, input bit o);
        bit hit;
        m_outp = 1'b0;
        if (l) begin
            m_pat = p;
            m_q.delete();
            m_cnt = 0;
            m_state = 0;
        end else if (e) begin
            m_q.push_back(b);
            if (m_q.size() > PW) void'(m_q.pop_front());
            hit = (m_q.size() == PW);
            for (int i = 0; i < m_q.size(); i++)
                if (m_q[i] != m_pat[PW - 1 - i]) hit = 1'b0;
            if (hit) begin
                m_outp = 1'b1;
                m_cnt++;
                if (!o) m_q.delete();
            end
            m_state = m_border();
        end
    endtask

    task automatic drive(input bit e, input bit b, input bit l, input logic [3:0] p, input bit o);
        @(negedge clk);
        en = e; inp = b; load = l; pattern_in = p; overlap = o;
        @(posedge clk);
        model_step(e, b, l, p, o);
        #1;
    endtask

    task automatic test_reset();
        #12;
        n_checks++; if (outp !== 1'b0) begin n_fail++; $display("FAIL reset_outp: got %0b want 0", outp); end
        n_checks++; if (state !== 2'd0) begin n_fail++; $display("FAIL reset_state: got %0d want 0", state); end
        n_checks++; if (cnt !== 8'd0) begin n_fail++; $display("FAIL reset_cnt: got %0d want 0", cnt); end
        n_checks++; if (cnt2 !== 2'd0) begin n_fail++; $display("FAIL reset_cnt2: got %0d want 0", cnt2); end
        @(negedge clk);
        rst = 1'b1;
        model_reset();
    endtask

    task automatic test_overlap();
        drive(1'b0, 1'b0, 1'b1, 4'b1011, 1'b1);
        for (int i = 0; i < 7; i++) begin
            drive(1'b1, STREAM[i] != 0, 1'b0, 4'b0000, 1'b1);
            n_checks++; if (state !== 2'(ST_OVL[i])) begin n_fail++; $display("FAIL ovl_state[%0d]: got %0d want %0d", i, state, ST_OVL[i]); end
            n_checks++; if (outp !== 1'(PU_OVL[i])) begin n_fail++; $display("FAIL ovl_outp[%0d]: got %0b want %0d", i, outp, PU_OVL[i]); end
        end
        n_checks++; if (cnt !== 8'd2) begin n_fail++; $display("FAIL ovl_cnt: got %0d want 2", cnt); end
    endtask

    task automatic test_nonoverlap();
        drive(1'b0, 1'b0, 1'b1, 4'b1011, 1'b0);
        for (int i = 0; i < 7; i++) begin
            drive(1'b1, STREAM[i] != 0, 1'b0, 4'b0000, 1'b0);
            n_checks++; if (state !== 2'(ST_NOV[i])) begin n_fail++; $display("FAIL nov_state[%0d]: got %0d want %0d", i, state, ST_NOV[i]); end
            n_checks++; if (outp !== 1'(PU_NOV[i])) begin n_fail++; $display("FAIL nov_outp[%0d]: got %0b want %0d", i, outp, PU_NOV[i]); end
        end
        n_checks++; if (cnt !== 8'd1) begin n_fail++; $display("FAIL nov_cnt: got %0d want 1", cnt); end
    endtask

    task automatic test_en_gaps();
        drive(1'b0, 1'b0, 1'b1, 4'b1011, 1'b1);
        for (int i = 0; i < 7; i++) begin
            drive(1'b1, STREAM[i] != 0, 1'b0, 4'b0000, 1'b1);
            n_checks++; if (state !== 2'(ST_OVL[i])) begin n_fail++; $display("FAIL gap_state[%0d]: got %0d want %0d", i, state, ST_OVL[i]); end
            n_checks++; if (outp !== 1'(PU_OVL[i])) begin n_fail++; $display("FAIL gap_outp[%0d]: got %0b want %0d", i, outp, PU_OVL[i]); end
            drive(1'b0, 1'($urandom_range(0, 1)), 1'b0, 4'b0000, 1'b1);
            n_checks++; if (outp !== 1'b0) begin n_fail++; $display("FAIL gap_idle_outp[%0d]: got %0b want 0", i, outp); end
            n_checks++; if (state !== 2'(ST_OVL[i])) begin n_fail++; $display("FAIL gap_idle_state[%0d]: got %0d want %0d", i, state, ST_OVL[i]); end
        end
        n_checks++; if (cnt !== 8'd2) begin n_fail++; $display("FAIL gap_cnt: got %0d want 2", cnt); end
    endtask

    task automatic test_load();
        int exp_st[4];
        int exp_pu[4];
        int bits[4];
        exp_st = '{1, 2, 3, 1};
        exp_pu = '{0, 0, 0, 1};
        bits   = '{0, 1, 1, 0};
        drive(1'b0, 1'b0, 1'b1, 4'b1011, 1'b1);
        for (int i = 0; i < 6; i++) drive(1'b1, STREAM[i] != 0, 1'b0, 4'b0000, 1'b1);
        n_checks++; if (cnt !== 8'd1 || state !== 2'd3) begin n_fail++; $display("FAIL load_pre: cnt %0d state %0d want 1 3", cnt, state); end
        // Coincident en with a bit that would start a prefix of the new pattern.
        drive(1'b1, 1'b0, 1'b1, 4'b0110, 1'b1);
        n_checks++; if (state !== 2'd0) begin n_fail++; $display("FAIL load_state: got %0d want 0", state); end
        n_checks++; if (cnt !== 8'd0) begin n_fail++; $display("FAIL load_cnt: got %0d want 0", cnt); end
        n_checks++; if (outp !== 1'b0) begin n_fail++; $display("FAIL load_outp: got %0b want 0", outp); end
        for (int i = 0; i < 4; i++) begin
            drive(1'b1, bits[i] != 0, 1'b0, 4'b0000, 1'b1);
            n_checks++; if (state !== 2'(exp_st[i])) begin n_fail++; $display("FAIL load_seq_state[%0d]: got %0d want %0d", i, state, exp_st[i]); end
            n_checks++; if (outp !== 1'(exp_pu[i])) begin n_fail++; $display("FAIL load_seq_outp[%0d]: got %0b want %0d", i, outp, exp_pu[i]); end
        end
        n_checks++; if (cnt !== 8'd1) begin n_fail++; $display("FAIL load_seq_cnt: got %0d want 1", cnt); end
    endtask

    task automatic test_saturation();
        int pulses;
        int want2;
        pulses = 0;
        drive(1'b0, 1'b0, 1'b1, 4'b1011, 1'b0);
        for (int r = 0; r < 5; r++) begin
            for (int b = 0; b < 4; b++) begin
                drive(1'b1, STREAM[b] != 0, 1'b0, 4'b0000, 1'b0);
                if (outp2 === 1'b1) pulses++;
            end
            want2 = (r + 1 > 3) ? 3 : r + 1;
            n_checks++; if (cnt2 !== 2'(want2)) begin n_fail++; $display("FAIL sat_cnt2[%0d]: got %0d want %0d", r, cnt2, want2); end
            n_checks++; if (cnt !== 8'(r + 1)) begin n_fail++; $display("FAIL sat_cnt8[%0d]: got %0d want %0d", r, cnt, r + 1); end
        end
        n_checks++; if (pulses != 5) begin n_fail++; $display("FAIL sat_pulses: got %0d want 5", pulses); end
    endtask

    task automatic test_async_reset();
        int exp_st[4];
        int exp_pu[4];
        int bits[7];
        exp_st = '{1, 2, 3, 1};
        exp_pu = '{0, 0, 0, 1};
        bits   = '{0, 1, 1, 0, 1, 0, 1};
        drive(1'b0, 1'b0, 1'b1, 4'b0110, 1'b1);
        for (int i = 0; i < 7; i++) begin
            drive(1'b1, bits[i] != 0, 1'b0, 4'b0000, 1'b1);
            n_checks++; if (state !== 2'(m_state) || outp !== m_outp) begin n_fail++; $display("FAIL arst_pre[%0d]: state %0d outp %0b want %0d %0b", i, state, outp, m_state, m_outp); end
        end
        n_checks++; if (cnt !== 8'(m_cnt) || m_cnt == 0) begin n_fail++; $display("FAIL arst_pre_cnt: got %0d want %0d (nonzero)", cnt, m_cnt); end
        #2;
        rst = 1'b0;
        #1;
        n_checks++; if (state !== 2'd0) begin n_fail++; $display("FAIL arst_state: got %0d want 0", state); end
        n_checks++; if (cnt !== 8'd0 || cnt2 !== 2'd0) begin n_fail++; $display("FAIL arst_cnt: got %0d/%0d want 0/0", cnt, cnt2); end
        n_checks++; if (outp !== 1'b0) begin n_fail++; $display("FAIL arst_outp: got %0b want 0", outp); end
        model_reset();
        @(negedge clk);
        rst = 1'b1;
        // Pattern must be back at 1011 and no pre-reset bits may contribute.
        for (int i = 0; i < 4; i++) begin
            drive(1'b1, STREAM[i] != 0, 1'b0, 4'b0000, 1'b1);
            n_checks++; if (state !== 2'(exp_st[i])) begin n_fail++; $display("FAIL arst_post_state[%0d]: got %0d want %0d", i, state, exp_st[i]); end
            n_checks++; if (outp !== 1'(exp_pu[i])) begin n_fail++; $display("FAIL arst_post_outp[%0d]: got %0b want %0d", i, outp, exp_pu[i]); end
        end
    endtask

    task automatic test_random();
        bit e, b, l, o;
        logic [3:0] p;
        int want2;
        for (int n = 0; n < 400; n++) begin
            l = ($urandom_range(0, 24) == 0);
            e = ($urandom_range(0, 3) != 0);
            b = 1'($urandom_range(0, 1));
            o = 1'($urandom_range(0, 1));
            p = 4'($urandom_range(0, 15));
            drive(e, b, l, p, o);
            want2 = (m_cnt > 3) ? 3 : m_cnt;
            n_checks++; if (outp !== m_outp) begin n_fail++; $display("FAIL rnd_outp[%0d]: got %0b want %0b", n, outp, m_outp); end
            n_checks++; if (state !== 2'(m_state)) begin n_fail++; $display("FAIL rnd_state[%0d]: got %0d want %0d", n, state, m_state); end
            n_checks++; if (cnt !== 8'((m_cnt > 255) ? 255 : m_cnt)) begin n_fail++; $display("FAIL rnd_cnt[%0d]: got %0d want %0d", n, cnt, m_cnt); end
            n_checks++; if (cnt2 !== 2'(want2) || outp2 !== m_outp || state2 !== 2'(m_state)) begin
                n_fail++; $display("FAIL rnd_dut2[%0d]: cnt %0d outp %0b state %0d want %0d %0b %0d", n, cnt2, outp2, state2, want2, m_outp, m_state);
            end
        end
    endtask

    initial begin
        model_reset();
        test_reset();
        test_overlap();
        test_nonoverlap();
        test_en_gaps();
        test_load();
        test_saturation();
        test_async_reset();
        test_random();
        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

    initial begin
        #2000000;
        $display("FAIL watchdog: time limit reached before end of test");
        $fatal(1);
    end

endmodule

// File: doc/seq_detector_param.md
SEQ_DETECTOR_PARAM -- requirements
Module: seq_detector_param

Interface
REQ-001 SHALL have parameter PAT_W, default 4, giving pattern length in bits (legal 2..16).
REQ-002 SHALL have parameter CNT_W, default 8, giving match counter width.
REQ-003 SHALL have parameter PAT_RST, default 4'b1011 (PAT_W bits), giving the pattern register value at reset.
REQ-004 SHALL have port clk, input, 1 bit: single clock; all state updates on the rising edge.
REQ-005 SHALL have port rst, input, 1 bit: reset, asynchronous and active-low.
REQ-006 SHALL have port en, input, 1 bit: inp is sampled this cycle.
REQ-007 SHALL have port inp, input, 1 bit: serial data bit.
REQ-008 SHALL have port load, input, 1 bit: latch pattern_in into the pattern register.
REQ-009 SHALL have port pattern_in, input, PAT_W bits: new pattern; bit PAT_W-1 is the first bit received.
REQ-010 SHALL have port overlap, input, 1 bit: 1 = overlapping detection, 0 = non-overlapping.
REQ-011 SHALL have port outp, output, 1 bit: registered one-cycle match pulse.
REQ-012 SHALL have port state, output, $clog2(PAT_W) bits: current matched-prefix length, range 0..PAT_W-1.
REQ-013 SHALL have port match_cnt, output, CNT_W bits: saturating count of matches.

Function
REQ-014 SHALL sample inp at a rising edge only when en=1 and load=0; when en=0, all registers SHALL hold and outp SHALL be 0 the next cycle.
REQ-015 SHALL keep a history of the last PAT_W accepted bits and a fill count, saturating at PAT_W, of accepted bits since the last reset, load or non-overlapping match.
REQ-016 SHALL register outp=1 for exactly one cycle after the edge that accepts a bit where fill count reaches or stays at PAT_W and history equals the pattern register; otherwise outp SHALL be 0.
REQ-017 SHALL set state after each accepted bit to the largest k < PAT_W, with k no greater than the fill count, such that the last k bits equal the first k pattern bits.
REQ-018 SHALL, on a match with overlap=1, keep the history and fill count, so state takes the longest proper prefix-suffix.
REQ-019 SHALL, on a match with overlap=0, clear the fill count to 0 and set state to 0.
REQ-020 SHALL, when load=1 at an edge, take pattern_in, clear history, fill count, state and match_cnt, and force outp to 0; load SHALL take priority over en, and a coincident bit SHALL be discarded.
REQ-021 SHALL increment match_cnt by 1 on each match and hold it at 2^CNT_W-1 with no wrap.
REQ-022 SHALL sample overlap at the matching edge; changing it mid-stream SHALL affect only subsequent matches.
REQ-023 SHALL produce the outp pulse, state update and match_cnt increment from the same edge, with latency 1 cycle.

Reset
REQ-024 SHALL, while rst=0, immediately force outp=0, state=0, match_cnt=0, history=0, fill count=0, and pattern register=PAT_RST, independent of clk.
REQ-025 SHALL, on rst deassertion, accept the first bit at the first rising edge with en=1.
REQ-026 SHALL discard any partial match on reset mid-stream, so no outp pulse results from pre-reset bits.

Structure
REQ-027 SHALL place shared constants in package seq_det_pkg: default PAT_W, CNT_W, PAT_RST, and a function computing the state width.
REQ-028 SHALL implement the prefix-suffix computation (history, fill count, pattern -> next state, match) in combinational sub-module seq_det_prefix; the top SHALL hold only the registers and counter.

Verification
REQ-029 SHALL cover: PAT_W=4, pattern 1011, overlap=1, en=1, bits 1,0,1,1,0,1,1 -> state 1,2,3,1,2,3,1; outp pulses after bits 4 and 7; match_cnt=2.
REQ-030 SHALL cover: same stream with overlap=0 -> state 1,2,3,0,0,1,1; single outp pulse after bit 4; match_cnt=1.
REQ-031 SHALL cover: en toggled low between each bit of the REQ-029 stream -> identical pulses and state trace, with outp never high in an en=0 cycle.
REQ-032 SHALL cover: load pattern_in=0110 after bits 1,0,1 -> state=0 and match_cnt=0; then bits 0,1,1,0 -> one pulse after the 4th bit.
REQ-033 SHALL cover: CNT_W=2 with stream 1011 repeated 5 times, overlap=0 -> 5 pulses; match_cnt reads 1,2,3,3,3.
REQ-034 SHALL cover: rst=0 asserted between clock edges after bits 1,0,1 -> outputs clear immediately; after release, bit 1 gives no pulse and state=1.
